// File: rtl/cpu_gpr_wb_arbiter.sv
// Round-robin writeback arbiter for the single GPR file write port.
// Requesters use a valid/ready handshake. The winning write is registered
// into a one-stage buffer that drives the active-low regfile write port.
// Writes to register 0 are dropped when ZERO_REG is set.
// Cycles with two or more valid requests are counted in a saturating counter.
module cpu_gpr_wb_arbiter #(
  parameter int DATA     = 32,
  parameter int ADDR     = 5,
  parameter int REQ      = 3,
  parameter int ZERO_REG = 1,
  parameter int CNT      = 16
) (
  input  logic                 clk,
  input  logic                 reset_,
  input  logic [REQ-1:0]       req_valid,
  input  logic [REQ*ADDR-1:0]  req_addr,
  input  logic [REQ*DATA-1:0]  req_data,
  output logic [REQ-1:0]       req_ready,
  output logic                 rf_we_,
  output logic [ADDR-1:0]      rf_waddr,
  output logic [DATA-1:0]      rf_wdata,
  output logic [CNT-1:0]       conflict_cnt
);

  localparam int PW = $clog2(REQ);
  localparam logic [PW-1:0] LAST = PW'(REQ - 1);

  logic [PW-1:0]   ptr_q, ptr_d;
  logic            we_n_q, we_n_d;
  logic [ADDR-1:0] waddr_q, waddr_d;
  logic [DATA-1:0] wdata_q, wdata_d;
  logic [CNT-1:0]  cnt_q, cnt_d;

  logic [REQ-1:0]  grant;
  logic [PW-1:0]   gnt_idx;
  logic            found;
  logic            transfer;
  logic [ADDR-1:0] sel_addr;
  logic [DATA-1:0] sel_data;

  // Round-robin scan starting at ptr_q; first valid requester wins.
  always_comb begin
    int unsigned idx;
    logic [PW-1:0] pidx;
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    pidx    = '0;
    for (int unsigned k = 0; k < REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= REQ) idx = idx - REQ;
      pidx = PW'(idx);
      if (!found && req_valid[pidx]) begin
        found       = 1'b1;
        grant[pidx] = 1'b1;
        gnt_idx     = pidx;
      end
    end
  end

  assign req_ready = reset_ ? grant : '0;
  assign transfer  = |grant;

  // Next-state for pointer, output buffer and conflict counter.
  always_comb begin
    ptr_d    = ptr_q;
    we_n_d   = 1'b1;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    sel_addr = req_addr[gnt_idx*ADDR +: ADDR];
    sel_data = req_data[gnt_idx*DATA +: DATA];
    if (transfer) begin
      ptr_d   = (gnt_idx == LAST) ? '0 : gnt_idx + PW'(1);
      waddr_d = sel_addr;
      wdata_d = sel_data;
      // Register 0 still completes the handshake and loads the buffer; only the enable is suppressed.
      we_n_d  = (ZERO_REG != 0) && (sel_addr == '0);
    end
    if (($countones(req_valid) > 1) && (cnt_q != '1)) cnt_d = cnt_q + CNT'(1);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      ptr_q   <= '0;
      we_n_q  <= 1'b1;
      waddr_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      we_n_q  <= we_n_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rf_we_       = we_n_q;
  assign rf_waddr     = waddr_q;
  assign rf_wdata     = wdata_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_gpr_wb_arbiter.sv
// Directed bench for cpu_gpr_wb_arbiter.
// Three instances share one stimulus: default, ZERO_REG=0, and CNT=4.
// Expected regfile writes of the default instance go through a scoreboard queue.
module tb_cpu_gpr_wb_arbiter;
  localparam int DATA = 32;
  localparam int ADDR = 5;
  localparam int REQ  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset_;
  logic [REQ-1:0]      req_valid;
  logic [REQ*ADDR-1:0] req_addr;
  logic [REQ*DATA-1:0] req_data;

  logic [REQ-1:0] rdy_a, rdy_z, rdy_c;
  logic           we_a, we_z, we_c;
  logic [ADDR-1:0] waddr_a, waddr_z, waddr_c;
  logic [DATA-1:0] wdata_a, wdata_z, wdata_c;
  logic [15:0]    cnt_a, cnt_z;
  logic [3:0]     cnt_c;

  cpu_gpr_wb_arbiter #(.DATA(DATA), .ADDR(ADDR), .REQ(REQ), .ZERO_REG(1), .CNT(16)) dut_a (
    .clk(clk), .reset_(reset_), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(rdy_a), .rf_we_(we_a), .rf_waddr(waddr_a), .rf_wdata(wdata_a), .conflict_cnt(cnt_a));

  cpu_gpr_wb_arbiter #(.DATA(DATA), .ADDR(ADDR), .REQ(REQ), .ZERO_REG(0), .CNT(16)) dut_z (
    .clk(clk), .reset_(reset_), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(rdy_z), .rf_we_(we_z), .rf_waddr(waddr_z), .rf_wdata(wdata_z), .conflict_cnt(cnt_z));

  cpu_gpr_wb_arbiter #(.DATA(DATA), .ADDR(ADDR), .REQ(REQ), .ZERO_REG(1), .CNT(4)) dut_c (
    .clk(clk), .reset_(reset_), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(rdy_c), .rf_we_(we_c), .rf_waddr(waddr_c), .rf_wdata(wdata_c), .conflict_cnt(cnt_c));

  typedef struct packed {
    logic [ADDR-1:0] a;
    logic [DATA-1:0] d;
  } wr_t;

  wr_t sb[$];
  int total = 0;
  int bad   = 0;
  int unsigned exp16 = 0;
  int unsigned exp4  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [ADDR-1:0] a, input logic [DATA-1:0] d);
    req_addr[i*ADDR +: ADDR] = a;
    req_data[i*DATA +: DATA] = d;
  endtask

  // One clock cycle: drive, check grant, model pushes, edge, check registered outputs.
  task automatic step(input logic rst, input logic [REQ-1:0] v, input logic [REQ-1:0] er);
    wr_t e;
    logic [ADDR-1:0] a;
    reset_    = rst;
    req_valid = v;
    #1;
    check("ready_a", rdy_a, er);
    check("ready_z", rdy_z, er);
    check("ready_c", rdy_c, er);
    if (rst) begin
      for (int i = 0; i < REQ; i++) begin
        if (er[i]) begin
          a = req_addr[i*ADDR +: ADDR];
          if (a != '0) sb.push_back({a, req_data[i*DATA +: DATA]});
        end
      end
    end
    if (!rst) begin
      exp16 = 0;
      exp4  = 0;
    end else if ($countones(v) >= 2) begin
      if (exp16 < 65535) exp16++;
      if (exp4 < 15) exp4++;
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("we_write", we_a, 1'b0);
      check("waddr", waddr_a, e.a);
      check("wdata", wdata_a, e.d);
    end else begin
      check("we_idle", we_a, 1'b1);
    end
    check("cnt16", cnt_a, exp16);
    check("cnt4", cnt_c, exp4);
  endtask

  initial begin
    reset_    = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;

    // Reset with all requesters valid
    set_req(0, 5'd1, 32'hA0);
    set_req(1, 5'd2, 32'hA1);
    set_req(2, 5'd3, 32'hA2);
    step(1'b0, 3'b111, 3'b000);
    step(1'b0, 3'b111, 3'b000);
    check("rst_waddr", waddr_a, 0);
    check("rst_wdata", wdata_a, 0);
    check("rst_we_c", we_c, 1'b1);

    // Fairness: six cycles all valid, first grant to requester 0
    step(1'b1, 3'b111, 3'b001);
    step(1'b1, 3'b111, 3'b010);
    step(1'b1, 3'b111, 3'b100);
    step(1'b1, 3'b111, 3'b001);
    step(1'b1, 3'b111, 3'b010);
    step(1'b1, 3'b111, 3'b100);
    check("cnt_after_rr", cnt_a, 6);
    step(1'b1, 3'b000, 3'b000);

    // Single request and hold of address/data afterwards
    set_req(1, 5'd5, 32'hDEADBEEF);
    step(1'b1, 3'b010, 3'b010);
    step(1'b1, 3'b000, 3'b000);
    check("hold_waddr", waddr_a, 5);
    check("hold_wdata", wdata_a, 32'hDEADBEEF);

    // Zero register write from requester 2 (ptr=2)
    set_req(2, 5'd0, 32'h1234);
    step(1'b1, 3'b100, 3'b100);
    check("zr_waddr", waddr_a, 0);
    check("zr_wdata", wdata_a, 32'h1234);
    check("z0_we", we_z, 1'b0);
    check("z0_waddr", waddr_z, 0);
    check("z0_wdata", wdata_z, 32'h1234);
    // Pointer wrapped to 0
    set_req(0, 5'd6, 32'h600);
    step(1'b1, 3'b111, 3'b001);

    // Reset mid-operation: accept addr 7, then reset at the next edge
    set_req(1, 5'd7, 32'h77);
    step(1'b1, 3'b010, 3'b010);
    step(1'b0, 3'b111, 3'b000);
    check("mid_waddr", waddr_a, 0);
    check("mid_wdata", wdata_a, 0);
    check("mid_we_z", we_z, 1'b1);
    // Pointer back at 0: requester 1 wins over requester 2
    set_req(1, 5'd8, 32'h88);
    step(1'b1, 3'b110, 3'b010);

    // Saturation: two requesters alternate for 20 cycles (ptr=2 at start)
    set_req(0, 5'd9, 32'h900);
    set_req(1, 5'd10, 32'hA00);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 3'b011, (k % 2 == 0) ? 3'b001 : 3'b010);
    end
    check("cnt4_sat", cnt_c, 15);
    check("cnt16_nosat", cnt_a, 21);
    step(1'b1, 3'b000, 3'b000);
    check("cnt4_hold", cnt_c, 15);
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cpu_gpr_wb_arbiter.md
Name: cpu_gpr_wb_arbiter

Overview:
- Shares the single write port of the general-purpose register file among REQ writeback requesters (ALU, load unit, mul/div, …).
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Registers the winning write into a one-stage output buffer that drives the regfile write port.
- Suppresses architectural writes to register 0 when ZERO_REG is enabled, and counts conflict cycles for performance monitoring.

Parameters:
- DATA, 32, data width of a register write.
- ADDR, 5, register address width (GprAddrWidth).
- REQ, 3, number of writeback requesters, 2..8.
- ZERO_REG, 1, 1 = address 0 is hardwired zero and writes to it are dropped; 0 = address 0 is an ordinary register.
- CNT, 16, width of the conflict counter.

Ports:
- clk  input  1  clock.
- reset_  input  1  synchronous, active-low reset.
- req_valid  input  REQ  bit i = requester i presents a write.
- req_addr  input  REQ*ADDR  packed destination addresses; slice i = requester i.
- req_data  input  REQ*DATA  packed write data; slice i = requester i.
- req_ready  output  REQ  one-hot (or zero) grant; bit i = requester i accepted this cycle.
- rf_we_  output  1  active-low write enable to the regfile write port.
- rf_waddr  output  ADDR  regfile write address.
- rf_wdata  output  DATA  regfile write data.
- conflict_cnt  output  CNT  saturating count of cycles with ≥2 valid requests.

Behaviour:
- Interface: one clock `clk`; reset `reset_` is synchronous and active-low. All state updates only on the rising edge of `clk`.
- Reset (`reset_`=0 sampled at an edge):
  - rf_we_=1, rf_waddr=0, rf_wdata=0.
  - conflict_cnt=0.
  - Round-robin pointer ptr=0.
  - Any write held in the output stage is discarded and never reaches the regfile.
- Arbitration (combinational from req_valid and ptr):
  - Scan indices ptr, ptr+1, …, REQ-1, 0, …, ptr-1; the first with req_valid=1 wins.
  - req_ready has exactly that bit set; req_ready=0 when no request is valid.
  - req_ready is forced to 0 while reset_=0.
- Handshake:
  - Transfer on requester i occurs when req_valid[i] & req_ready[i].
  - A requester must hold valid, addr and data stable until it sees ready.
  - Losers keep valid asserted; no transfer happens for them.
  - ready never depends on the output stage: the port accepts one write every cycle, with no backpressure.
- Pointer update:
  - On a transfer by i at an edge, ptr <= (i+1) mod REQ.
  - With no transfer, ptr holds.
  - Wrap-around: a grant to index REQ-1 sets ptr=0.
  - Guarantees a continuously valid requester is granted within REQ cycles.
- Output stage (latency 1):
  - At the edge of a transfer by i: rf_waddr <= addr_i, rf_wdata <= data_i, rf_we_ <= 0.
  - Exception: if ZERO_REG=1 and addr_i==0, rf_we_ <= 1. The transfer still completes, ptr still advances, and waddr/wdata are still loaded.
  - With no transfer, rf_we_ <= 1, and rf_waddr/rf_wdata hold their previous values.
- Simultaneous events:
  - Two requesters writing the same address in consecutive cycles produce two regfile writes in grant order; the later grant wins architecturally.
  - Multiple same-cycle requests are serialised over successive cycles, never merged.
- conflict_cnt:
  - Increments at each edge where popcount(req_valid) ≥ 2 and reset_=1.
  - Saturates at 2^CNT-1 and does not wrap.
- No latches; all outputs are registered except req_ready.

Test Plan:
- Reset: hold reset_=0 for 2 cycles with req_valid=3'b111 -> req_ready=0, rf_we_=1, waddr=0, wdata=0, conflict_cnt=0; on release, the first grant goes to requester 0.
- Single request: req_valid=3'b010, addr1=5, data1=32'hDEADBEEF -> same-cycle req_ready=3'b010; next cycle rf_we_=0, rf_waddr=5, rf_wdata=32'hDEADBEEF; the cycle after, rf_we_=1.
- Round-robin fairness: hold req_valid=3'b111 for 6 cycles from ptr=0 -> grants 0,1,2,0,1,2; regfile writes appear one cycle later in the same order; conflict_cnt=6.
- Zero register: ZERO_REG=1, requester 2 writes addr 0, data 32'h1234 -> req_ready[2]=1, ptr becomes 0, rf_we_ stays 1; with ZERO_REG=0 the same stimulus gives rf_we_=0, rf_waddr=0.
- Reset mid-operation: accept addr 7 at edge N, assert reset_=0 sampled at edge N+1 -> at N+1 rf_we_=1, waddr=0, ptr=0; no write of addr 7 completes after edge N+1.
- Saturation: CNT=4, hold req_valid=3'b011 for 20 cycles -> conflict_cnt reaches 15 and holds; requesters 0 and 1 alternate grants throughout.
